// File: rtl/instr_encoder_if.sv
// Instruction encoder bus: run control, decoded field bundle in, machine word out.
// master = loader/harness side, slave = encoder side.
interface instr_encoder_if;
    logic        start;
    logic [31:0] start_addr;

    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [1:0]  cls;
    logic [3:0]  cond;
    logic [3:0]  alu_op;
    logic        s_bit;
    logic        imm_sel;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [4:0]  shamt;
    logic [1:0]  sh_type;
    logic [3:0]  rot;
    logic [7:0]  imm8;
    logic        mem_load;
    logic        mem_up;
    logic [11:0] imm12;
    logic [31:0] target;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_done;
    logic        err_range;

    modport master (
        output start, start_addr,
        output in_valid, in_last, cls, cond, alu_op, s_bit, imm_sel,
        output rn, rd, rm, shamt, sh_type, rot, imm8, mem_load, mem_up, imm12, target,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_done, err_range
    );

    modport slave (
        input  start, start_addr,
        input  in_valid, in_last, cls, cond, alu_op, s_bit, imm_sel,
        input  rn, rd, rm, shamt, sh_type, rot, imm8, mem_load, mem_up, imm12, target,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_done, err_range
    );
endinterface

// File: rtl/instr_encoder.sv
// Streaming ARM-subset instruction encoder (DP, LDR/STR, B, BL).
// Turns decoded field bundles into 32-bit words tagged with their byte address,
// through a one-entry output register; throughput 1 word/cycle.
// Optional branch range/alignment check: define INSTR_ENC_RANGE_CHK_EN.
module instr_encoder #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS  = 1024
) (
    input  logic             clk,
    input  logic             reset,   // active-low, asynchronous
    instr_encoder_if.slave   s_bus
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [31:0]       r_out_addr;

    logic              w_in_ready;
    logic              w_acc;
    logic              w_start_ok;
    logic              w_cnt_last;
    logic              w_xfer;

    logic              w_dp_s;
    logic [11:0]       w_op2;
    logic [31:0]       w_off;
    logic              w_br_err;
    logic [23:0]       w_imm24;
    logic [31:0]       w_enc;
    logic              w_unused_bits;

    assign w_in_ready = (r_state == ST_RUN) & (~r_out_valid | s_bus.out_ready);
    assign w_acc      = s_bus.in_valid & w_in_ready;
    assign w_start_ok = s_bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_cnt_last = (r_count == CNT_W'(MAX_WORDS - 1));
    assign w_xfer     = r_out_valid & s_bus.out_ready;

    // Compare-class ALU ops (TST/TEQ/CMP/CMN, 8..B) always set flags.
    assign w_dp_s = s_bus.s_bit | (s_bus.alu_op[3:2] == 2'b10);
    assign w_op2  = s_bus.imm_sel ? {s_bus.rot, s_bus.imm8}
                                  : {s_bus.shamt, s_bus.sh_type, 1'b0, s_bus.rm};

    // Branch offset is relative to the pipelined PC (word address + 8).
    assign w_off = s_bus.target - (r_addr + 32'd8);

`ifdef INSTR_ENC_RANGE_CHK_EN
    // Unaligned target or offset not representable as signed 26 bits.
    assign w_br_err = (s_bus.target[1:0] != 2'b00) |
                      ~((&w_off[31:25]) | ~(|w_off[31:25]));
`else
    assign w_br_err = 1'b0;
`endif

    assign w_imm24       = w_br_err ? 24'd0 : w_off[25:2];
    assign w_unused_bits = ^{w_off[31:26], w_off[1:0], s_bus.target[1:0]};

    // Field packing per instruction class.
    always_comb begin
        w_enc = 32'd0;
        case (s_bus.cls)
            2'b00:   w_enc = {s_bus.cond, 2'b00, s_bus.imm_sel, s_bus.alu_op, w_dp_s,
                              s_bus.rn, s_bus.rd, w_op2};
            2'b01:   w_enc = {s_bus.cond, 2'b01, 1'b0, 1'b1, s_bus.mem_up, 1'b0, 1'b0,
                              s_bus.mem_load, s_bus.rn, s_bus.rd, s_bus.imm12};
            default: w_enc = {s_bus.cond, 3'b101, s_bus.cls[0], w_imm24};
        endcase
    end

    // Run state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Run sequencing: start, last/limit, output drain.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (s_bus.start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_acc && (s_bus.in_last || w_cnt_last)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_xfer) w_state_nxt = ST_DONE;
            ST_DONE:  if (s_bus.start) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Address counter and word count; start only reloads outside RUN/DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= RESET_ADDR;
            r_count <= '0;
        end else if (w_start_ok) begin
            r_addr  <= s_bus.start_addr;
            r_count <= '0;
        end else if (w_acc) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count + CNT_W'(1);
        end
    end

    // One-entry output register; holds while the sink stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= 32'd0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_enc;
            r_out_addr  <= r_addr;
        end else if (s_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef INSTR_ENC_RANGE_CHK_EN
    logic r_err;

    // Sticky branch error, cleared by an accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   r_err <= 1'b0;
        else if (w_start_ok)          r_err <= 1'b0;
        else if (w_acc && w_br_err && s_bus.cls[1]) r_err <= 1'b1;
    end

    assign s_bus.err_range = r_err;
`else
    assign s_bus.err_range = 1'b0;
`endif

    assign s_bus.in_ready  = w_in_ready;
    assign s_bus.out_valid = r_out_valid;
    assign s_bus.out_instr = r_out_instr;
    assign s_bus.out_addr  = r_out_addr;
    assign s_bus.out_done  = (r_state == ST_DRAIN) & w_xfer;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: behavioural model + per-cycle compare,
// directed literal vectors, randomized runs.
module tb_instr_encoder;

    localparam int          MAXW  = 8;
    localparam logic [31:0] RST_A = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_encoder_if bus();

    instr_encoder #(.RESET_ADDR(RST_A), .MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .s_bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding from field definitions, plain arithmetic.
    function automatic logic [32:0] encode(
        input logic [1:0] c, input logic [3:0] cd, input logic [3:0] op,
        input logic sb, input logic is, input logic [3:0] n, input logic [3:0] d,
        input logic [3:0] m, input logic [4:0] sa, input logic [1:0] st,
        input logic [3:0] ro, input logic [7:0] i8, input logic ld, input logic up,
        input logic [11:0] i12, input logic [31:0] tg, input logic [31:0] pc);
        logic [31:0] w, off, imm;
        logic e;
`ifdef INSTR_ENC_RANGE_CHK_EN
        int so;
`endif
        e = 1'b0;
        w = 32'(cd) << 28;
        case (c)
            2'd0: begin
                w = w | (32'(is) << 25) | (32'(op) << 21) | (32'(n) << 16) | (32'(d) << 12);
                if (sb || (op >= 4'd8 && op <= 4'd11)) w = w | (32'd1 << 20);
                if (is) w = w + 32'(ro) * 256 + 32'(i8);
                else    w = w + 32'(sa) * 128 + 32'(st) * 32 + 32'(m);
            end
            2'd1: w = w | (32'd1 << 26) | (32'd1 << 24) | (32'(up) << 23) | (32'(ld) << 20)
                        | (32'(n) << 16) | (32'(d) << 12) | 32'(i12);
            default: begin
                off = tg - pc - 32'd8;
                imm = (off >> 2) & 32'h00FF_FFFF;
`ifdef INSTR_ENC_RANGE_CHK_EN
                so = $signed(off);
                if ((tg % 4) != 0 || so < -(1 << 25) || so >= (1 << 25)) begin
                    e   = 1'b1;
                    imm = 32'd0;
                end
`endif
                w = w | (32'd5 << 25) | (32'(c[0]) << 24) | imm;
            end
        endcase
        return {e, w};
    endfunction

    // ---------------- behavioural model ----------------
    int          m_phase;   // 0 idle, 1 running, 2 draining, 3 finished
    logic        m_valid;
    logic [31:0] m_instr, m_oaddr, m_addr;
    int          m_cnt;
    logic        m_err;

    wire m_rdy   = (m_phase == 1) && (!m_valid || bus.out_ready);
    wire m_acc   = bus.in_valid && m_rdy;
    wire m_xfer  = m_valid && bus.out_ready;
    wire m_done  = (m_phase == 2) && m_xfer;
    wire m_start = bus.start && (m_phase == 0 || m_phase == 3);
    wire [32:0] m_enc = encode(bus.cls, bus.cond, bus.alu_op, bus.s_bit, bus.imm_sel,
                               bus.rn, bus.rd, bus.rm, bus.shamt, bus.sh_type, bus.rot,
                               bus.imm8, bus.mem_load, bus.mem_up, bus.imm12, bus.target,
                               m_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_valid <= 1'b0; m_instr <= 32'd0; m_oaddr <= 32'd0;
            m_addr <= RST_A; m_cnt <= 0; m_err <= 1'b0;
        end else begin
            if (m_acc) begin
                m_valid <= 1'b1;
                m_instr <= m_enc[31:0];
                m_oaddr <= m_addr;
                m_addr  <= m_addr + 32'd4;
                m_cnt   <= m_cnt + 1;
                if (m_enc[32]) m_err <= 1'b1;
                if (bus.in_last || m_cnt + 1 == MAXW) m_phase <= 2;
            end else if (m_xfer) begin
                m_valid <= 1'b0;
            end
            if (m_done) m_phase <= 3;
            if (m_start) begin
                m_phase <= 1; m_addr <= bus.start_addr; m_cnt <= 0; m_err <= 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_instr", bus.out_instr, m_instr);
            chk("out_addr", bus.out_addr, m_oaddr);
        end
        chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        chk("out_done", 32'(bus.out_done), 32'(m_done));
        chk("err_range", 32'(bus.err_range), 32'(m_err));
        if (bus.out_done) done_cnt++;
    end

    // Sink ready driver.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus tasks (entered/left at posedge+1) ----------------
    task automatic do_start(input logic [31:0] a);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_addr = a;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic push(input logic last);
        int n;
        n = 0;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
                break;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic set_dp(input logic [3:0] c, input logic [3:0] op, input logic s,
                          input logic im, input logic [3:0] n, input logic [3:0] d,
                          input logic [3:0] m, input logic [4:0] sa, input logic [1:0] st,
                          input logic [3:0] ro, input logic [7:0] i8);
        bus.cls = 2'b00; bus.cond = c; bus.alu_op = op; bus.s_bit = s; bus.imm_sel = im;
        bus.rn = n; bus.rd = d; bus.rm = m; bus.shamt = sa; bus.sh_type = st;
        bus.rot = ro; bus.imm8 = i8;
    endtask

    task automatic set_mem(input logic [3:0] c, input logic ld, input logic up,
                           input logic [3:0] n, input logic [3:0] d, input logic [11:0] i12);
        bus.cls = 2'b01; bus.cond = c; bus.mem_load = ld; bus.mem_up = up;
        bus.rn = n; bus.rd = d; bus.imm12 = i12;
    endtask

    task automatic set_br(input logic [3:0] c, input logic link, input logic [31:0] t);
        bus.cls = {1'b1, link}; bus.cond = c; bus.target = t;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (m_phase != 3) begin
            @(posedge clk); #1;
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL done_timeout: run did not finish in %0d cycles", n);
                break;
            end
        end
    endtask

    task automatic rand_fields(input logic [31:0] base);
        bus.cls = 2'($urandom); bus.cond = 4'($urandom); bus.alu_op = 4'($urandom);
        bus.s_bit = 1'($urandom); bus.imm_sel = 1'($urandom);
        bus.rn = 4'($urandom); bus.rd = 4'($urandom); bus.rm = 4'($urandom);
        bus.shamt = 5'($urandom); bus.sh_type = 2'($urandom); bus.rot = 4'($urandom);
        bus.imm8 = 8'($urandom); bus.mem_load = 1'($urandom); bus.mem_up = 1'($urandom);
        bus.imm12 = 12'($urandom);
        case ($urandom_range(0, 3))
            0:       bus.target = $urandom;
            1:       bus.target = base + 32'd2 + 32'($urandom_range(0, 64));
            default: bus.target = base + (32'($urandom_range(0, 128)) << 2) - 32'd256;
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.start = 1'b0; bus.start_addr = 32'd0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        set_dp(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 5'd0, 2'd0, 4'h0, 8'h00);
        bus.mem_load = 1'b0; bus.mem_up = 1'b0; bus.imm12 = 12'd0; bus.target = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_done", 32'(bus.out_done), 32'd0);
        chk("rst_err_range", 32'(bus.err_range), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed DP / MEM words.
        do_start(32'h0);
        set_dp(4'hE, 4'h4, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 5'd0, 2'd0, 4'd0, 8'd5);
        push(1'b0); #3;
        chk("dp_add_instr", bus.out_instr, 32'hE282_1005);
        chk("dp_add_addr", bus.out_addr, 32'h0);
        set_dp(4'hE, 4'hA, 1'b0, 1'b0, 4'd3, 4'd0, 4'd4, 5'd0, 2'd0, 4'd0, 8'd0);
        push(1'b0); #3;
        chk("dp_cmp_instr", bus.out_instr, 32'hE153_0004);
        chk("dp_cmp_addr", bus.out_addr, 32'h4);
        set_mem(4'hE, 1'b1, 1'b1, 4'd1, 4'd0, 12'd8);
        push(1'b0); #3;
        chk("ldr_instr", bus.out_instr, 32'hE591_0008);
        done_cnt = 0;
        set_mem(4'hE, 1'b0, 1'b1, 4'd1, 4'd0, 12'd8);
        push(1'b1); #3;
        chk("str_instr", bus.out_instr, 32'hE581_0008);
        chk("str_addr", bus.out_addr, 32'hC);
        wait_done();
        chk("mem_done_pulses", 32'(done_cnt), 32'd1);

        // Branches.
        do_start(32'h100);
        set_br(4'hE, 1'b1, 32'h200);
        push(1'b1); #3;
        chk("bl_instr", bus.out_instr, 32'hEB00_003E);
        chk("bl_addr", bus.out_addr, 32'h100);
        wait_done();
        do_start(32'h10);
        set_br(4'hE, 1'b0, 32'h0);
        push(1'b1); #3;
        chk("b_back_instr", bus.out_instr, 32'hEAFF_FFFA);
        wait_done();

        // Backpressure.
        rdy_mode = 2;
        do_start(32'h40);
        set_dp(4'hE, 4'h0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 5'd0, 2'd0, 4'd0, 8'hFF);
        push(1'b0); #3;
        chk("bp_a_instr", bus.out_instr, 32'hE200_00FF);
        set_dp(4'hE, 4'hD, 1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 5'd0, 2'd0, 4'd0, 8'h01);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_instr", bus.out_instr, 32'hE200_00FF);
            chk("bp_hold_addr", bus.out_addr, 32'h40);
        end
        rdy_mode = 0;
        done_cnt = 0;
        push(1'b1); #3;
        chk("bp_b_instr", bus.out_instr, 32'hE3A0_3001);
        chk("bp_b_addr", bus.out_addr, 32'h44);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("bp_done_pulses", 32'(done_cnt), 32'd1);
        chk("done_in_ready", 32'(bus.in_ready), 32'd0);

        // Unaligned branch target.
        do_start(32'h0);
        set_br(4'hE, 1'b0, 32'h202);
        push(1'b1); #3;
`ifdef INSTR_ENC_RANGE_CHK_EN
        chk("rng_instr", bus.out_instr, 32'hEA00_0000);
        chk("rng_err", 32'(bus.err_range), 32'd1);
`else
        chk("rng_instr", bus.out_instr, 32'hEA00_007E);
        chk("rng_err", 32'(bus.err_range), 32'd0);
`endif
        wait_done();
        do_start(32'h20); #3;
        chk("rng_err_clr", 32'(bus.err_range), 32'd0);
        @(posedge clk); #1;

        // Word limit forces the run to finish.
        done_cnt = 0;
        for (int i = 0; i < MAXW; i++) begin
            set_dp(4'hE, 4'h4, 1'b0, 1'b1, 4'd1, 4'd1, 4'd0, 5'd0, 2'd0, 4'd0, 8'(i));
            push(1'b0);
        end
        #3;
        chk("max_last_addr", bus.out_addr, 32'h20 + 32'(4 * (MAXW - 1)));
        chk("max_in_ready", 32'(bus.in_ready), 32'd0);
        wait_done();
        chk("max_done_pulses", 32'(done_cnt), 32'd1);

        // Reset in the middle of a run drops the pending word.
        rdy_mode = 2;
        do_start(32'h300);
        set_dp(4'hE, 4'h4, 1'b1, 1'b1, 4'd7, 4'd7, 4'd0, 5'd0, 2'd0, 4'd1, 8'h33);
        push(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_instr", bus.out_instr, 32'd0);
        chk("mid_rst_out_addr", bus.out_addr, 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;

        // Randomized runs, checked by the compare process.
        for (int r = 0; r < 30; r++) begin
            logic [31:0] base;
            int n;
            rdy_mode = int'($urandom_range(0, 1));
            base = 32'($urandom_range(0, 1023)) << 2;
            do_start(base);
            n = int'($urandom_range(1, 11));
            for (int i = 0; i < n; i++) begin
                if (m_phase != 1) break;
                rand_fields(base + 32'(4 * i));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                push(i == n - 1);
            end
            wait_done();
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
